// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial stream converter:
// lane-order encoding and the idle fill helper used for dout/output_index.
package p2s_pkg;

    // Lane emission order selected by the MSB_FIRST parameter.
    typedef enum logic {
        P2S_LSB_FIRST = 1'b0,
        P2S_MSB_FIRST = 1'b1
    } p2s_order_e;

    // Widest field the idle fill helper can produce (DW and IW must fit).
    localparam int P2S_MAX_W = 64;

    // Returns a vector with the low w bits set; callers slice it to width.
    function automatic logic [P2S_MAX_W-1:0] p2s_idle_fill(input int w);
        logic [P2S_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < P2S_MAX_W; i++) begin
            if (i < w) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/p2s_stream_if.sv
// Bundle of the parallel input side and the serial output side.
// The converter uses the slave view; the producer/consumer pair uses master.
interface p2s_stream_if #(
    parameter int DW        = 32,
    parameter int BUS_WIDTH = 12,
    parameter int IW        = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        din           [BUS_WIDTH];
    logic [IW-1:0]        input_indices [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] lane_mask;
    logic [DW-1:0]        dout;
    logic [IW-1:0]        output_index;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output in_valid, din, input_indices, lane_mask, out_ready,
        input  in_ready, dout, output_index, out_valid, out_last
    );

    modport slave (
        input  in_valid, din, input_indices, lane_mask, out_ready,
        output in_ready, dout, output_index, out_valid, out_last
    );
endinterface

// File: rtl/p2s_lane_pick.sv
// Combinational lane selector: picks the first pending lane in the
// configured order and flags when it is the only pending lane.
module p2s_lane_pick
    import p2s_pkg::*;
#(
    parameter int BUS_WIDTH = 12,
    parameter bit MSB_FIRST = 1'b0,
    parameter int SW        = $clog2(BUS_WIDTH)
) (
    input  logic [BUS_WIDTH-1:0] pend,
    output logic [BUS_WIDTH-1:0] onehot,
    output logic [SW-1:0]        sel,
    output logic                 single
);

    localparam bit ORDER_MSB = (MSB_FIRST == bit'(P2S_MSB_FIRST));
    localparam logic [BUS_WIDTH-1:0] ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

    // Scan lanes in emission order and keep the first pending one.
    always_comb begin
        int  lane;
        logic found;
        onehot = '0;
        sel    = '0;
        found  = 1'b0;
        lane   = 0;
        for (int k = 0; k < BUS_WIDTH; k++) begin
            lane = ORDER_MSB ? (BUS_WIDTH - 1 - k) : k;
            if (pend[lane] && !found) begin
                found        = 1'b1;
                onehot[lane] = 1'b1;
                sel          = SW'(lane);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    always_comb begin
        single = (pend != '0) && ((pend & (pend - ONE)) == '0);
    end

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter with valid/ready on both sides.
// A word of BUS_WIDTH lanes is latched together with its lane mask; enabled
// lanes are then emitted one per accepted output beat, last beat flagged.
//
// Handshake: a transfer happens on a side in any cycle where its valid and
// ready are both high at the clock edge. out_valid/dout/output_index/out_last
// stay stable while out_valid=1 and out_ready=0. in_ready never looks at
// in_valid, but it does look at out_ready so a new word can be taken in the
// same cycle as the previous word's last beat.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BUS_WIDTH = 12,
    parameter int IW        = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic          clk,
    input logic          rst,
    p2s_stream_if.slave  bus
);

    localparam int SW = $clog2(BUS_WIDTH);

    localparam logic [P2S_MAX_W-1:0] DATA_FILL_W = p2s_idle_fill(DW);
    localparam logic [P2S_MAX_W-1:0] TAG_FILL_W  = p2s_idle_fill(IW);
    localparam logic [DW-1:0]        DATA_FILL   = DATA_FILL_W[DW-1:0];
    localparam logic [IW-1:0]        TAG_FILL    = TAG_FILL_W[IW-1:0];

    logic [DW-1:0]        data_q [BUS_WIDTH];
    logic [IW-1:0]        tag_q  [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] pend_q;
    logic [BUS_WIDTH-1:0] pend_d;
    logic [BUS_WIDTH-1:0] pick_onehot;
    logic [SW-1:0]        pick_sel;
    logic                 pick_single;
    logic                 out_valid;
    logic                 out_last;
    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;

    p2s_lane_pick #(
        .BUS_WIDTH (BUS_WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .SW        (SW)
    ) u_pick (
        .pend   (pend_q),
        .onehot (pick_onehot),
        .sel    (pick_sel),
        .single (pick_single)
    );

    // Handshake qualifiers for both sides.
    always_comb begin
        out_valid = |pend_q;
        out_last  = out_valid && pick_single;
        in_ready  = !out_valid || (bus.out_ready && out_last);
        in_fire   = bus.in_valid && in_ready;
        out_fire  = out_valid && bus.out_ready;
    end

    // Next pending mask: a new word replaces it (its last beat, if any, is
    // leaving this same cycle); otherwise a taken beat clears its lane.
    always_comb begin
        pend_d = pend_q;
        if (in_fire) begin
            pend_d = bus.lane_mask;
        end else if (out_fire) begin
            pend_d = pend_q & ~pick_onehot;
        end
    end

    // Pending-lane register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Lane data and tag storage, loaded whole on each accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < BUS_WIDTH; k++) begin
                data_q[k] <= DATA_FILL;
                tag_q[k]  <= TAG_FILL;
            end
        end else if (in_fire) begin
            for (int k = 0; k < BUS_WIDTH; k++) begin
                data_q[k] <= bus.din[k];
                tag_q[k]  <= bus.input_indices[k];
            end
        end
    end

    // Output mux: selected lane when valid, all-ones when idle.
    always_comb begin
        bus.dout         = DATA_FILL;
        bus.output_index = TAG_FILL;
        if (out_valid) begin
            bus.dout         = data_q[pick_sel];
            bus.output_index = tag_q[pick_sel];
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.in_ready  = in_ready;

endmodule

// File: tb/tb_p2s_stream.sv
// Bench for p2s_stream: one LSB-first and one MSB-first instance share the
// same stimulus; a queue-based model of each predicts the beat stream.
module tb_p2s_stream;

    localparam int DW = 32;
    localparam int BW = 12;
    localparam int IW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] tag;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus state ----------------
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] wd [BW];
    logic [IW-1:0] wt [BW];
    logic [BW-1:0] wm = '0;
    bit            fired;

    int checks = 0;
    int errors = 0;

    beat_t lsb_q[$];
    beat_t msb_q[$];

    p2s_stream_if #(.DW(DW), .BUS_WIDTH(BW), .IW(IW)) if_l ();
    p2s_stream_if #(.DW(DW), .BUS_WIDTH(BW), .IW(IW)) if_m ();

    assign if_l.in_valid  = in_valid;
    assign if_m.in_valid  = in_valid;
    assign if_l.out_ready = out_ready;
    assign if_m.out_ready = out_ready;
    assign if_l.lane_mask = wm;
    assign if_m.lane_mask = wm;
    for (genvar g = 0; g < BW; g++) begin : g_lanes
        assign if_l.din[g]           = wd[g];
        assign if_m.din[g]           = wd[g];
        assign if_l.input_indices[g] = wt[g];
        assign if_m.input_indices[g] = wt[g];
    end

    p2s_stream #(.DW(DW), .BUS_WIDTH(BW), .IW(IW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_l)
    );

    p2s_stream #(.DW(DW), .BUS_WIDTH(BW), .IW(IW), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_side(input string nm, input beat_t q[$],
                              input logic ov, input logic [DW-1:0] d,
                              input logic [IW-1:0] t, input logic ol, input logic ir);
        beat_t head;
        logic  exp_ir;
        head   = '1;
        if (q.size() > 0) head = q[0];
        exp_ir = (q.size() == 0) || (out_ready && q.size() == 1);
        check({nm, ".out_valid"},    64'(ov), 64'(q.size() > 0));
        check({nm, ".dout"},         64'(d),  64'(head.data));
        check({nm, ".output_index"}, 64'(t),  64'(head.tag));
        check({nm, ".out_last"},     64'(ol), 64'(q.size() == 1));
        check({nm, ".in_ready"},     64'(ir), 64'(exp_ir));
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic  exp_ir;
        beat_t b;
        #2;
        if (!rst) begin
            check_side("lsb", lsb_q, if_l.out_valid, if_l.dout, if_l.output_index,
                       if_l.out_last, if_l.in_ready);
            check_side("msb", msb_q, if_m.out_valid, if_m.dout, if_m.output_index,
                       if_m.out_last, if_m.in_ready);
        end
        exp_ir = (lsb_q.size() == 0) || (out_ready && lsb_q.size() == 1);
        fired  = 1'b0;
        @(posedge clk);
        if (rst) begin
            lsb_q.delete();
            msb_q.delete();
        end else begin
            if (out_ready && lsb_q.size() > 0) begin
                void'(lsb_q.pop_front());
                void'(msb_q.pop_front());
            end
            if (in_valid && exp_ir) begin
                fired = 1'b1;
                for (int k = 0; k < BW; k++) begin
                    if (wm[k]) begin
                        b.data = wd[k];
                        b.tag  = wt[k];
                        lsb_q.push_back(b);
                    end
                end
                for (int k = BW - 1; k >= 0; k--) begin
                    if (wm[k]) begin
                        b.data = wd[k];
                        b.tag  = wt[k];
                        msb_q.push_back(b);
                    end
                end
            end
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // seq=1: lane k carries data k+0x100 and tag k; otherwise random.
    task automatic load(input logic [BW-1:0] mask, input bit seq);
        for (int k = 0; k < BW; k++) begin
            wd[k] = seq ? (32'h100 + 32'(k)) : $urandom;
            wt[k] = seq ? IW'(k) : IW'($urandom_range(0, 15));
        end
        wm = mask;
    endtask

    // Raise in_valid and hold it until the word is taken (bounded).
    task automatic offer();
        int n;
        n        = 0;
        in_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!fired && n < 64);
        if (!fired) begin
            checks++;
            errors++;
            $error("FAIL offer_timeout observed=not_accepted expected=accepted");
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int k = 0; k < BW; k++) begin
            wd[k] = '0;
            wt[k] = '0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        // reset values
        run(1);

        // full mask, sequential data, out_ready held
        out_ready = 1'b1;
        load(12'hFFF, 1'b1);
        offer();
        in_valid = 1'b0;
        run(13);

        // sparse mask: MSB instance emits 7,5,0
        load(12'b0000_1010_0001, 1'b0);
        offer();
        in_valid = 1'b0;
        run(4);

        // stalls: out_ready pattern 1,0,0,1,0,0,...
        load(12'h00F, 1'b0);
        offer();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 3 == 0);
            cycle();
        end
        out_ready = 1'b1;
        run(2);

        // back-to-back words, second accepted with beat 1
        load(12'h003, 1'b1);
        offer();
        load(12'h0C0, 1'b1);
        offer();
        in_valid = 1'b0;
        run(4);

        // empty word, then single-lane word
        load(12'h000, 1'b0);
        offer();
        in_valid = 1'b0;
        run(1);
        load(12'h800, 1'b1);
        offer();
        in_valid = 1'b0;
        run(3);

        // reset after the third beat of a full word
        load(12'hFFF, 1'b0);
        offer();
        in_valid = 1'b0;
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    load(BW'($urandom) & BW'($urandom) & BW'($urandom), 1'b0);
                else
                    load(BW'($urandom), 1'b0);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (fired) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && lsb_q.size() > 0; i++) cycle();
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p2s_stream.md
# p2s_stream

Parametrised parallel-to-serial converter with full valid/ready handshaking on both sides. It latches a word of `BUS_WIDTH` lanes, each carrying data and an index tag, and emits only the lanes enabled by a per-word lane mask, one per accepted output beat. Lanes go out in a configurable order, and the last beat of each word is flagged. It sits between the parallel per-channel compute stages of the localizer and the serial consumer, replacing the fixed-rate, no-backpressure shifter.

## Interface
- `DW`, 32, data width per lane
- `BUS_WIDTH`, 12, number of lanes per word (≥2)
- `IW`, 4, index tag width per lane
- `MSB_FIRST`, 0, lane order: 0 emits lane 0 first; 1 emits lane `BUS_WIDTH-1` first

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  parallel word present
- `in_ready`  out  1  block can accept a word this cycle
- `din`  in  `DW` × `BUS_WIDTH`  lane data (unpacked array)
- `input_indices`  in  `IW` × `BUS_WIDTH`  lane index tags
- `lane_mask`  in  `BUS_WIDTH`  1 = lane is emitted
- `dout`  out  `DW`  current serial data
- `output_index`  out  `IW`  current lane tag
- `out_valid`  out  1  `dout`/`output_index` are valid
- `out_ready`  in  1  consumer accepts the beat
- `out_last`  out  1  current beat is the last enabled lane of its word

## Operation
- Input fire = `in_valid && in_ready`. On fire, the block latches all lanes, their tags and `lane_mask` into a pending mask `pend`.
- `out_valid = |pend`. The selected lane is the lowest set bit of `pend`, or the highest set bit if `MSB_FIRST=1`.
- `dout`/`output_index` show the selected lane. When `out_valid=0` they show all-ones (`{DW{1}}`, `{IW{1}}`).
- `out_last = out_valid && (pend has exactly one bit set)`.
- Output fire = `out_valid && out_ready`. It clears the selected bit of `pend`.
- `in_ready = !out_valid || (out_ready && out_last)`. This allows back-to-back words with no bubble.
- Simultaneous input fire and last-beat output fire: the new word's mask replaces `pend`. The old last beat is consumed in the same cycle.
- All-zero `lane_mask`: the word is accepted and produces no beats, and `in_ready` stays 1.
- While `out_valid=1` and `out_ready=0`, outputs are held stable (AXI-stream rules). The block never drops or reorders enabled lanes.
- `in_ready` has no combinational dependence on `in_valid`. It does depend combinationally on `out_ready`.

## Timing
- Reset values: `pend=0`, `out_valid=0`, `out_last=0`, `in_ready=1`, `dout`/`output_index` all-ones. Latched lane storage resets to all-ones.
- Reset mid-word: the remaining beats are discarded and the reset values appear in the cycle after `rst` is sampled high.
- Latency: input fire in cycle N gives the first beat valid in cycle N+1.
- Throughput with `out_ready` held 1: popcount(mask) cycles per word, one beat per cycle, and the next word's first beat follows the previous last beat with no gap.
- Single-lane mask: `out_valid` and `out_last` both assert in cycle N+1.

## Structure
- Package `p2s_pkg` holds the shared lane-order enum values (`P2S_LSB_FIRST`, `P2S_MSB_FIRST`) and the idle fill constants helper.
- Sub-module `p2s_lane_pick`, parametrised on `BUS_WIDTH` and `MSB_FIRST`, is purely combinational:
  - takes `pend`;
  - outputs the one-hot selection, a binary select and a `single` flag.
- The top level holds the data/tag registers, the `pend` register, the handshake logic and the output mux.

## Test plan
- Reset with `rst=1` for 2 cycles → `in_ready=1`, `out_valid=0`, `dout=32'hFFFFFFFF`, `output_index=4'hF`.
- Full mask 12'hFFF, lane k data = k+0x100, tag = k, `out_ready=1` → 12 beats, tags 0..11 in consecutive cycles, `out_last` only on tag 11, `in_ready` high on the tag-11 cycle.
- Mask 12'b0000_1010_0001, `MSB_FIRST=1` → beats tag 7, 5, 0 in that order, `out_last` on tag 0.
- Mask 12'h00F with `out_ready` toggling 1,0,0,1,… → each beat held stable while stalled, 4 beats total, no duplicates or losses.
- Two words offered back-to-back with masks 12'h003 then 12'h0C0 → beats 0,1,6,7 in 4 consecutive cycles, second word accepted in the cycle of beat 1.
- Mask 0 word followed by mask 12'h800 word → first word produces no beats, then a single beat tag 11 with `out_last=1`. Separately, assert `rst` after the 3rd beat of a full-mask word → `out_valid=0` next cycle and no further beats.
